md_issue_ctrl: RTL and testbench
================================

// Module: md_issue_ctrl
// PURPOSE
//  Execute-stage issue/hazard controller sitting directly upstream of the multiply/divide unit.
//  Decodes the E-stage instruction and drives the unit's start and HiLoWr inputs.
//  Freezes E and earlier while any MD-class instruction meets a busy unit, covering the
//  one-cycle gap between start and the unit raising its stall. Watchdogs each operation.
// PARAMETERS
//  TIMEOUT  16  max cycles from issue until md_busy falls; at TIMEOUT md_err sets, FSM frees
//  CNT_W    5   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  instr_E    in   32  instruction in Execute
//  valid_E    in   1   instr_E valid (0 = bubble)
//  md_busy    in   1   stall output of the multiply/divide unit
//  md_start   out  1   start to MD unit (combinational)
//  md_hilowr  out  2   01 = write Hi, 10 = write Lo, 00 = none (combinational)
//  stall_E    out  1   freeze PC/F/D/E, insert bubble into M (combinational)
//  md_state   out  2   FSM state, for debug
//  md_err     out  1   sticky watchdog error
// BEHAVIOUR
//  Decode: opcode 000000 only. funct 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
//   (muldiv); 010001 MTHI, 010011 MTLO (hlwr); 010000 MFHI, 010010 MFLO (hlrd).
//   md_class = valid_E & (muldiv|hlwr|hlrd).
//  free = (state==IDLE) & ~md_busy.
//  md_start  = valid_E & muldiv & free.
//  md_hilowr = free & valid_E & hlwr ? (MTHI ? 01 : 10) : 00.
//  stall_E   = md_class & ~free.
//  md_start and nonzero md_hilowr are never both 1 (distinct funct).
//  FSM, 2-bit state:
//   IDLE(00): md_start -> LAUNCH, cnt<=1. Otherwise hold.
//   LAUNCH(01): exactly 1 cycle, md_busy not yet valid; -> BUSY, cnt<=cnt+1.
//   BUSY(10): md_busy=1 -> stay, cnt<=cnt+1; md_busy=0 -> IDLE, cnt<=0.
//   any non-IDLE state with cnt==TIMEOUT -> IDLE, md_err<=1, cnt<=0 (takes priority).
//   State 11 is illegal; decodes as IDLE.
//  Latency: MULT 5 cycles issue->free (LAUNCH + 4 BUSY); DIV 10; divide by zero same
//   timing as DIV. An MD-class instruction in E stalls until the cycle state==IDLE and
//   md_busy==0, then issues that same cycle.
//  hlrd never issues anything; it only stalls, so MFHI/MFLO read final Hi/Lo.
//  hlwr stalls while busy so an in-flight result cannot overwrite MTHI/MTLO data.
//  valid_E=0 while busy: stall_E=0 (bubble passes), FSM keeps tracking md_busy.
//  Reset (async, any state incl. mid-operation): state=IDLE, cnt=0, md_err=0; outputs
//   md_start=0, md_hilowr=00, stall_E=0, md_state=00 while reset=0.
//  md_busy=1 seen in IDLE (e.g. after reset release mid-op of the unit): no state change,
//   MD-class instructions stall until it falls.
//  md_err clears only on reset.
// STRUCTURE
//  md_pkg: opcode/funct localparams (MULT..MTLO), state encodings IDLE/LAUNCH/BUSY,
//   HiLoWr codes HLW_NONE/HLW_HI/HLW_LO.
//  Sub-module md_decode (combinational): instr_E -> muldiv, hlwr, hlrd, is_hi.
//  Top: FSM + watchdog counter (only flops: state, cnt, md_err); output logic as above.
// TESTING
//  1 MULT in E, idle, md_busy low -> md_start=1 cycle 0; state 01,10,10,10,10,00; 5 cycles total.
//  2 DIV then MFLO next cycle -> MFLO stall_E=1 for 10 cycles, released with md_busy low
//    and state 00; md_start never asserted for MFLO.
//  3 MULT then MTHI -> md_hilowr stays 00 while busy; 01 on first free cycle, stall_E=0 there.
//  4 md_busy held 1 after issue -> md_err=1 after cnt reaches 16, state 00, later MULT issues.
//  5 reset low mid-DIV (state 10) -> all outputs 0 immediately (async); after release with
//    md_busy=1, MFHI stalls until md_busy=0.
//  6 valid_E=0 with MULT encoding, or opcode 000001 with funct 011000 -> no start, no stall.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl_pkg
// Shared definitions for the execute-stage multiply/divide issue controller:
//   - SPECIAL opcode and the funct codes of the Hi/Lo instruction group
//   - FSM state encodings (IDLE / LAUNCH / BUSY; 2'b11 is illegal)
//   - HiLoWr codes driven to the multiply/divide unit
//   - decoded instruction class struct produced by md_issue_ctrl_decode
// ---------------------------------------------------------------------------
package md_issue_ctrl_pkg;

  // Only R-type (SPECIAL) instructions belong to the MD group.
  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  // Multiply / divide operations, all of which start the unit.
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Hi/Lo moves.
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  // Controller FSM. 2'b11 is never entered; the logic treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    BUSY   = 2'b10
  } md_state_e;

  // Hi/Lo write strobe codes.
  typedef enum logic [1:0] {
    HLW_NONE = 2'b00,
    HLW_HI   = 2'b01,
    HLW_LO   = 2'b10
  } hilowr_e;

  // Instruction classes seen by the controller.
  typedef struct packed {
    logic muldiv;  // MULT/MULTU/DIV/DIVU
    logic hlwr;    // MTHI/MTLO
    logic hlrd;    // MFHI/MFLO
    logic is_hi;   // targets Hi rather than Lo (meaningful for hlwr/hlrd)
  } md_dec_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl_if
// Bundles the Execute-stage instruction, the multiply/divide unit handshake
// and the controller's stall/debug outputs.
//   instr_E    32  instruction in Execute
//   valid_E     1  instr_E valid (0 = bubble)
//   md_busy     1  stall output of the multiply/divide unit
//   md_start    1  start strobe to the unit
//   md_hilowr   2  Hi/Lo write strobe to the unit (01 Hi, 10 Lo, 00 none)
//   stall_E     1  freeze PC/F/D/E, bubble into M
//   md_state    2  controller FSM state (debug)
//   md_err      1  sticky watchdog error
// Modports:
//   master - pipeline/unit side, drives instruction and md_busy
//   slave  - the issue controller
// ---------------------------------------------------------------------------
interface md_issue_ctrl_if;

  logic [31:0] instr_E;
  logic        valid_E;
  logic        md_busy;
  logic        md_start;
  logic [1:0]  md_hilowr;
  logic        stall_E;
  logic [1:0]  md_state;
  logic        md_err;

  modport master (
    output instr_E,
    output valid_E,
    output md_busy,
    input  md_start,
    input  md_hilowr,
    input  stall_E,
    input  md_state,
    input  md_err
  );

  modport slave (
    input  instr_E,
    input  valid_E,
    input  md_busy,
    output md_start,
    output md_hilowr,
    output stall_E,
    output md_state,
    output md_err
  );

endinterface

// File: rtl/md_issue_ctrl_decode.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl_decode
// Purely combinational classification of the Execute-stage instruction into
// the groups the issue controller cares about.
//   instr  in   32  instruction word
//   dec    out  md_dec_t {muldiv, hlwr, hlrd, is_hi}
// Anything that is not opcode SPECIAL, or SPECIAL with an unrelated funct,
// decodes to all-zero.
// ---------------------------------------------------------------------------
module md_issue_ctrl_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output md_dec_t     dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = opcode_of(instr);
  assign funct  = funct_of(instr);

  // rs/rt/rd/shamt play no part in issue control.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec = '0;
    if (opcode == OP_SPECIAL) begin
      case (funct)
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
          dec.muldiv = 1'b1;
        end
        FN_MTHI: begin
          dec.hlwr  = 1'b1;
          dec.is_hi = 1'b1;
        end
        FN_MTLO: begin
          dec.hlwr  = 1'b1;
        end
        FN_MFHI: begin
          dec.hlrd  = 1'b1;
          dec.is_hi = 1'b1;
        end
        FN_MFLO: begin
          dec.hlrd  = 1'b1;
        end
        default: begin
          dec = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
// Execute-stage issue/hazard controller in front of the multiply/divide unit.
// Decodes the E-stage instruction, drives the unit's start and HiLoWr inputs,
// and stalls E and earlier while an MD-class instruction meets a busy unit.
// A LAUNCH state covers the cycle after start in which the unit has not yet
// raised md_busy. A watchdog frees the controller if md_busy never falls.
// Parameters:
//   TIMEOUT  cycles from issue at which the watchdog fires (md_err sets)
//   CNT_W    watchdog counter width, 2**CNT_W > TIMEOUT
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low (0 = reset)
//   bus    md_issue_ctrl_if.slave (instr_E, valid_E, md_busy in;
//          md_start, md_hilowr, stall_E, md_state, md_err out)
// ---------------------------------------------------------------------------
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic           clk,
  input logic           reset,
  md_issue_ctrl_if.slave bus
);

  if ((1 << CNT_W) <= TIMEOUT) begin : g_bad_cnt_w
    $error("md_issue_ctrl: CNT_W too narrow for TIMEOUT");
  end

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  md_dec_t dec;
  logic    idle;
  logic    free;
  logic    md_class;
  logic    start_raw;
  logic    hlw_raw;
  logic    timeout_hit;

  md_issue_ctrl_decode u_decode (
    .instr (bus.instr_E),
    .dec   (dec)
  );

  // The illegal encoding 2'b11 behaves exactly like IDLE.
  assign idle     = !((state_q == LAUNCH) || (state_q == BUSY));
  assign free     = idle & ~bus.md_busy;
  assign md_class = bus.valid_E & (dec.muldiv | dec.hlwr | dec.hlrd);

  assign start_raw   = bus.valid_E & dec.muldiv & free;
  assign hlw_raw     = bus.valid_E & dec.hlwr & free;
  assign timeout_hit = !idle && (cnt_q == CNT_W'(TIMEOUT));

  // Outputs are forced low while reset is held, even though md_busy may
  // still be high from an operation the unit was running.
  assign bus.md_start  = reset & start_raw;
  assign bus.md_hilowr = (reset & hlw_raw) ? (dec.is_hi ? HLW_HI : HLW_LO) : HLW_NONE;
  assign bus.stall_E   = reset & md_class & ~free;
  assign bus.md_state  = state_q;
  assign bus.md_err    = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Watchdog expiry overrides normal sequencing so a hung unit can never
  // freeze the pipeline indefinitely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (timeout_hit) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        LAUNCH: begin
          state_d = BUSY;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        BUSY: begin
          if (bus.md_busy) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          if (start_raw) begin
            state_d = LAUNCH;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl
// Drives cycle-by-cycle scenarios into md_issue_ctrl. Each driven cycle pushes
// its expected outputs to a queue; a negedge process pops and compares them.
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  md_issue_ctrl_if bus ();

  md_issue_ctrl #(
    .TIMEOUT (16),
    .CNT_W   (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       start;
    logic [1:0] hlw;
    logic       stall;
    logic [1:0] state;
    logic       err;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [5:0] fn);
    return {op, 5'd3, 5'd4, 5'd0, 5'd0, fn};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs (just after a rising edge) and queue the
  // outputs expected during that cycle.
  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic busy, input logic e_start,
                               input logic [1:0] e_hlw, input logic e_stall,
                               input logic [1:0] e_state, input logic e_err,
                               input string tag);
    bus.instr_E = instr;
    bus.valid_E = valid;
    bus.md_busy = busy;
    exp_q.push_back(exp_t'{e_start, e_hlw, e_stall, e_state, e_err, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".start"}, 32'(bus.md_start), 32'd0);
    checkOutput({tag, ".hlw"},   32'(bus.md_hilowr), 32'd0);
    checkOutput({tag, ".stall"}, 32'(bus.stall_E), 32'd0);
    checkOutput({tag, ".state"}, 32'(bus.md_state), 32'd0);
    checkOutput({tag, ".err"},   32'(bus.md_err), 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput({e.tag, ".start"}, 32'(bus.md_start), 32'(e.start));
      checkOutput({e.tag, ".hlw"},   32'(bus.md_hilowr), 32'(e.hlw));
      checkOutput({e.tag, ".stall"}, 32'(bus.stall_E), 32'(e.stall));
      checkOutput({e.tag, ".state"}, 32'(bus.md_state), 32'(e.state));
      checkOutput({e.tag, ".err"},   32'(bus.md_err), 32'(e.err));
    end
  end

  initial begin
    logic [31:0] nop;
    logic [31:0] mult;
    logic [31:0] multu;
    logic [31:0] div;
    logic [31:0] mfhi;
    logic [31:0] mflo;
    logic [31:0] mthi;
    logic [31:0] mtlo;
    logic [31:0] regimm_mult;

    nop         = 32'd0;
    mult        = rtype(6'b000000, F_MULT);
    multu       = rtype(6'b000000, F_MULTU);
    div         = rtype(6'b000000, F_DIV);
    mfhi        = rtype(6'b000000, F_MFHI);
    mflo        = rtype(6'b000000, F_MFLO);
    mthi        = rtype(6'b000000, F_MTHI);
    mtlo        = rtype(6'b000000, F_MTLO);
    regimm_mult = rtype(6'b000001, F_MULT);

    // Reset held with an MD instruction presented and the unit busy.
    bus.instr_E = mult;
    bus.valid_E = 1'b1;
    bus.md_busy = 1'b1;
    #2;
    checkAllZero("reset");
    bus.valid_E = 1'b0;
    bus.md_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // MULT: LAUNCH then 4 BUSY cycles; bubbles pass while busy.
    applyStimulus(mult, 1, 0, 1, 2'b00, 0, 2'd0, 0, "mult.c0");
    applyStimulus(nop,  0, 1, 0, 2'b00, 0, 2'd1, 0, "mult.c1");
    for (int i = 2; i <= 4; i++)
      applyStimulus(mult, 0, 1, 0, 2'b00, 0, 2'd2, 0, $sformatf("mult.c%0d", i));
    applyStimulus(nop,  0, 0, 0, 2'b00, 0, 2'd2, 0, "mult.c5");
    applyStimulus(nop,  0, 0, 0, 2'b00, 0, 2'd0, 0, "mult.c6");

    // DIV followed by MFLO: 10 stalled cycles, no start for MFLO.
    applyStimulus(div,  1, 0, 1, 2'b00, 0, 2'd0, 0, "div.c0");
    applyStimulus(mflo, 1, 1, 0, 2'b00, 1, 2'd1, 0, "div.c1");
    for (int i = 2; i <= 9; i++)
      applyStimulus(mflo, 1, 1, 0, 2'b00, 1, 2'd2, 0, $sformatf("div.c%0d", i));
    applyStimulus(mflo, 1, 0, 0, 2'b00, 1, 2'd2, 0, "div.c10");
    applyStimulus(mflo, 1, 0, 0, 2'b00, 0, 2'd0, 0, "div.c11");

    // MULT then MTHI: write strobe held off until free, then MTLO.
    applyStimulus(mult, 1, 0, 1, 2'b00, 0, 2'd0, 0, "mthi.c0");
    applyStimulus(mthi, 1, 1, 0, 2'b00, 1, 2'd1, 0, "mthi.c1");
    for (int i = 2; i <= 4; i++)
      applyStimulus(mthi, 1, 1, 0, 2'b00, 1, 2'd2, 0, $sformatf("mthi.c%0d", i));
    applyStimulus(mthi, 1, 0, 0, 2'b00, 1, 2'd2, 0, "mthi.c5");
    applyStimulus(mthi, 1, 0, 0, 2'b01, 0, 2'd0, 0, "mthi.c6");
    applyStimulus(mtlo, 1, 0, 0, 2'b10, 0, 2'd0, 0, "mtlo.c7");

    // Non-issuing cases: bubble with MULT bits, wrong opcode, idle MFHI.
    applyStimulus(mult,        0, 0, 0, 2'b00, 0, 2'd0, 0, "nv.mult");
    applyStimulus(regimm_mult, 1, 0, 0, 2'b00, 0, 2'd0, 0, "regimm");
    applyStimulus(mfhi,        1, 0, 0, 2'b00, 0, 2'd0, 0, "mfhi.idle");

    // Watchdog: md_busy never falls after MULTU.
    applyStimulus(multu, 1, 0, 1, 2'b00, 0, 2'd0, 0, "wd.c0");
    applyStimulus(nop,   0, 1, 0, 2'b00, 0, 2'd1, 0, "wd.c1");
    for (int i = 2; i <= 16; i++)
      applyStimulus(nop, 0, 1, 0, 2'b00, 0, 2'd2, 0, $sformatf("wd.c%0d", i));
    applyStimulus(mult, 1, 1, 0, 2'b00, 1, 2'd0, 1, "wd.c17");
    applyStimulus(div,  1, 0, 1, 2'b00, 0, 2'd0, 1, "wd.c18");
    applyStimulus(nop,  0, 1, 0, 2'b00, 0, 2'd1, 1, "wd.c19");
    applyStimulus(mfhi, 1, 1, 0, 2'b00, 1, 2'd2, 1, "wd.c20");

    // Asynchronous reset in the middle of the DIV (state BUSY).
    bus.instr_E = mfhi;
    bus.valid_E = 1'b1;
    bus.md_busy = 1'b1;
    reset       = 1'b0;
    #1;
    checkAllZero("arst");
    @(posedge clk);
    #1;
    checkAllZero("arst.hold");
    reset = 1'b1;

    // Unit still busy after reset release: MFHI stalls in IDLE.
    for (int i = 0; i < 3; i++)
      applyStimulus(mfhi, 1, 1, 0, 2'b00, 1, 2'd0, 0, $sformatf("post.c%0d", i));
    applyStimulus(mfhi, 1, 0, 0, 2'b00, 0, 2'd0, 0, "post.c3");
    applyStimulus(mult, 1, 0, 1, 2'b00, 0, 2'd0, 0, "post.c4");
    applyStimulus(nop,  0, 1, 0, 2'b00, 0, 2'd1, 0, "post.c5");

    @(negedge clk);
    #1;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
